// File: rtl/enemy_collision_dispatcher_pkg.sv
// Shared types and constants for the enemy collision dispatcher and its
// per-enemy hit trackers.
package enemy_collision_dispatcher_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    CLEARED = 1'b1
  } waveState_t;

  localparam int BULLET_TYPES = 3;
  localparam int ID_WIDTH     = 4;

  // Isolates the lowest set bit so simultaneous bullet types report one-hot.
  function automatic logic [BULLET_TYPES-1:0] lowestSetBit(input logic [BULLET_TYPES-1:0] req);
    return req & (~req + BULLET_TYPES'(1));
  endfunction

endpackage

// File: rtl/enemy_collision_dispatcher_hit_tracker.sv
// Per-enemy state: once-per-frame report flags, hit counter and alive bit.
// Hit inputs arrive already qualified by the dispatcher for this enemy.
module enemy_hit_tracker #(
  parameter int HITS_TO_KILL = 3
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic revive,
  input  logic shotHit,
  input  logic dirHit,
  input  logic dodgeHit,
  output logic shotFlag,
  output logic dirFlag,
  output logic dodgeFlag,
  output logic alive,
  output logic killPulse
);

  localparam logic [1:0] LAST_HIT = 2'(HITS_TO_KILL - 1);

  logic [1:0] hitCountReg;

  assign killPulse = shotHit && (hitCountReg == LAST_HIT);

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      shotFlag    <= 1'b0;
      dirFlag     <= 1'b0;
      dodgeFlag   <= 1'b0;
      alive       <= 1'b1;
      hitCountReg <= 2'd0;
    end else begin
      // A hit during the frame-start cycle already belongs to the new frame.
      if (startOfFrame) begin
        shotFlag  <= shotHit;
        dirFlag   <= dirHit;
        dodgeFlag <= dodgeHit;
      end else begin
        shotFlag  <= shotFlag | shotHit;
        dirFlag   <= dirFlag | dirHit;
        dodgeFlag <= dodgeFlag | dodgeHit;
      end

      if (revive) begin
        alive       <= 1'b1;
        hitCountReg <= 2'd0;
      end else if (killPulse) begin
        alive       <= 1'b0;
        hitCountReg <= 2'd0;
      end else if (shotHit) begin
        hitCountReg <= hitCountReg + 2'd1;
      end
    end
  end

endmodule

// File: rtl/enemy_collision_dispatcher.sv
// Pixel-rate collision arbitration for enemies: issues zero-latency border,
// dodge and shot events, and runs the wave-cleared / wave-restart sequence.
module enemy_collision_dispatcher
  import enemy_collision_dispatcher_pkg::*;
#(
  parameter int AMOUNT_OF_ENEMIES = 2,
  parameter int HITS_TO_KILL      = 3
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         pause,
  input  logic                         enemyDrawReq,
  input  logic                         headsUpDrawReq,
  input  logic                         headsDownDrawReq,
  input  logic [ID_WIDTH-1:0]          drawingRequestorId,
  input  logic [BULLET_TYPES-1:0]      bulletDrawReq,
  input  logic                         borderDrawReq,
  output logic                         changeDir,
  output logic                         dodgeBullet,
  output logic [BULLET_TYPES-1:0]      shotCollision,
  output logic [AMOUNT_OF_ENEMIES-1:0] aliveMap,
  output logic [7:0]                   killCount,
  output logic [3:0]                   waveNum,
  output logic                         waveClear
);

  logic [AMOUNT_OF_ENEMIES-1:0] selMask;
  logic [AMOUNT_OF_ENEMIES-1:0] shotFlags;
  logic [AMOUNT_OF_ENEMIES-1:0] dirFlags;
  logic [AMOUNT_OF_ENEMIES-1:0] dodgeFlags;
  logic [AMOUNT_OF_ENEMIES-1:0] killPulses;

  waveState_t stateReg, stateNext;
  logic [7:0] killCountReg;
  logic [3:0] waveNumReg;
  logic       waveClearReg;

  logic eventsEnabled, idValid, shotEvent, dirEvent, dodgeEvent, reviveAll;

  genvar gi;
  generate
    for (gi = 0; gi < AMOUNT_OF_ENEMIES; gi++) begin : genTracker
      // Out-of-range ids match no enemy, so they can never raise an event.
      assign selMask[gi] = (drawingRequestorId == ID_WIDTH'(gi));

      enemy_hit_tracker #(
        .HITS_TO_KILL(HITS_TO_KILL)
      ) tracker (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .revive      (reviveAll),
        .shotHit     (shotEvent & selMask[gi]),
        .dirHit      (dirEvent & selMask[gi]),
        .dodgeHit    (dodgeEvent & selMask[gi]),
        .shotFlag    (shotFlags[gi]),
        .dirFlag     (dirFlags[gi]),
        .dodgeFlag   (dodgeFlags[gi]),
        .alive       (aliveMap[gi]),
        .killPulse   (killPulses[gi])
      );
    end
  endgenerate

  always_comb begin
    eventsEnabled = !resetN && !pause && (stateReg == RUN);
    idValid       = |(selMask & aliveMap);

    shotEvent  = eventsEnabled && idValid && enemyDrawReq && (|bulletDrawReq)
                 && !(|(selMask & shotFlags));
    dirEvent   = eventsEnabled && idValid && enemyDrawReq && borderDrawReq
                 && !(|(selMask & dirFlags));
    dodgeEvent = eventsEnabled && idValid && !enemyDrawReq
                 && (headsUpDrawReq || headsDownDrawReq) && (|bulletDrawReq)
                 && !(|(selMask & dodgeFlags));

    changeDir     = dirEvent;
    dodgeBullet   = dodgeEvent;
    shotCollision = shotEvent ? lowestSetBit(bulletDrawReq) : '0;
  end

  // Wave FSM; the restart waits for an unpaused frame start so paused state stays frozen.
  always_comb begin
    stateNext = stateReg;
    reviveAll = 1'b0;
    case (stateReg)
      RUN: begin
        if (aliveMap == '0) stateNext = CLEARED;
      end
      CLEARED: begin
        if (startOfFrame && !pause) begin
          stateNext = RUN;
          reviveAll = 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      stateReg     <= RUN;
      killCountReg <= 8'd0;
      waveNumReg   <= 4'd0;
      waveClearReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      waveClearReg <= reviveAll;
      if (reviveAll) waveNumReg <= waveNumReg + 4'd1;
      if ((|killPulses) && (killCountReg != 8'hFF)) killCountReg <= killCountReg + 8'd1;
    end
  end

  assign killCount = killCountReg;
  assign waveNum   = waveNumReg;
  assign waveClear = waveClearReg;

endmodule

// File: tb/tb_enemy_collision_dispatcher.sv
// Self-checking bench: directed vector table, hand-written wave/reset
// sequences and random stimulus against a behavioural model.
module tb_enemy_collision_dispatcher;

  localparam int N = 2;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, pause;
  logic       enemyDrawReq, headsUpDrawReq, headsDownDrawReq, borderDrawReq;
  logic [3:0] drawingRequestorId;
  logic [2:0] bulletDrawReq;
  logic       changeDir, dodgeBullet, waveClear;
  logic [2:0] shotCollision;
  logic [N-1:0] aliveMap;
  logic [7:0] killCount;
  logic [3:0] waveNum;

  always #5 clk = ~clk;

  enemy_collision_dispatcher #(
    .AMOUNT_OF_ENEMIES(N),
    .HITS_TO_KILL     (H)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .pause             (pause),
    .enemyDrawReq      (enemyDrawReq),
    .headsUpDrawReq    (headsUpDrawReq),
    .headsDownDrawReq  (headsDownDrawReq),
    .drawingRequestorId(drawingRequestorId),
    .bulletDrawReq     (bulletDrawReq),
    .borderDrawReq     (borderDrawReq),
    .changeDir         (changeDir),
    .dodgeBullet       (dodgeBullet),
    .shotCollision     (shotCollision),
    .aliveMap          (aliveMap),
    .killCount         (killCount),
    .waveNum           (waveNum),
    .waveClear         (waveClear)
  );

  typedef struct packed {
    logic sof, pause, enemy, up, down, border;
    logic [3:0] id;
    logic [2:0] bullet;
  } stim_t;

  typedef struct packed {
    stim_t      in;
    logic       cd;
    logic       dg;
    logic [2:0] sc;
    logic [1:0] am;
    logic [7:0] kc;
  } vec_t;

  vec_t tbl [16];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state
  bit aliveM [N];
  int hitsM  [N];
  bit shotF  [N];
  bit dirF   [N];
  bit dodgeF [N];
  int kcM, waveM;
  bit clearedM, waveClearM;

  function automatic stim_t st(input logic sof, input logic pz, input logic en,
                               input logic up, input logic dn, input logic bd,
                               input logic [3:0] id, input logic [2:0] bl);
    stim_t s;
    s.sof = sof; s.pause = pz; s.enemy = en; s.up = up; s.down = dn;
    s.border = bd; s.id = id; s.bullet = bl;
    return s;
  endfunction

  function automatic vec_t mk(input stim_t s, input logic cd, input logic dg,
                              input logic [2:0] sc, input logic [1:0] am, input logic [7:0] kc);
    vec_t v;
    v.in = s; v.cd = cd; v.dg = dg; v.sc = sc; v.am = am; v.kc = kc;
    return v;
  endfunction

  function automatic logic [N-1:0] aliveVec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = aliveM[i];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      aliveM[i] = 1; hitsM[i] = 0; shotF[i] = 0; dirF[i] = 0; dodgeF[i] = 0;
    end
    kcM = 0; waveM = 0; clearedM = 0; waveClearM = 0;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    startOfFrame = s.sof; pause = s.pause; enemyDrawReq = s.enemy;
    headsUpDrawReq = s.up; headsDownDrawReq = s.down; borderDrawReq = s.border;
    drawingRequestorId = s.id; bulletDrawReq = s.bullet;
  endtask

  // Drives one pixel cycle, compares every output with the model, then
  // advances the model across the coming clock edge.
  task automatic applyAndCheck(input stim_t s);
    int id;
    bit valid, allDead;
    logic expCd, expDg;
    logic [2:0] expSc;
    @(negedge clk);
    drive(s);
    #1;
    id = int'(s.id);
    valid = 0;
    if (!s.pause && !clearedM && id < N) valid = aliveM[id];
    expSc = 3'b000; expCd = 0; expDg = 0;
    if (valid) begin
      if (s.enemy && !shotF[id])
        for (int b = 0; b < 3; b++)
          if (s.bullet[b] && expSc == 3'b000) expSc[b] = 1'b1;
      expCd = s.enemy && s.border && !dirF[id];
      expDg = (s.up || s.down) && (s.bullet != 0) && !s.enemy && !dodgeF[id];
    end
    check("changeDir", 8'(changeDir), 8'(expCd));
    check("dodgeBullet", 8'(dodgeBullet), 8'(expDg));
    check("shotCollision", 8'(shotCollision), 8'(expSc));
    check("aliveMap", 8'(aliveMap), 8'(aliveVec()));
    check("killCount", killCount, 8'(kcM));
    check("waveNum", 8'(waveNum), 8'(waveM));
    check("waveClear", 8'(waveClear), 8'(waveClearM));

    allDead = 1;
    for (int i = 0; i < N; i++) if (aliveM[i]) allDead = 0;
    if (s.sof)
      for (int i = 0; i < N; i++) begin shotF[i] = 0; dirF[i] = 0; dodgeF[i] = 0; end
    if (valid) begin
      if (expSc != 0) begin
        shotF[id] = 1;
        hitsM[id]++;
        if (hitsM[id] == H) begin
          aliveM[id] = 0; hitsM[id] = 0;
          if (kcM < 255) kcM++;
        end
      end
      if (expCd) dirF[id] = 1;
      if (expDg) dodgeF[id] = 1;
    end
    waveClearM = 0;
    if (clearedM && s.sof && !s.pause) begin
      clearedM = 0; waveClearM = 1; waveM = (waveM + 1) % 16;
      for (int i = 0; i < N; i++) begin aliveM[i] = 1; hitsM[i] = 0; end
    end else if (!clearedM && allDead) begin
      clearedM = 1;
    end
  endtask

  initial begin
    stim_t idle;
    stim_t rs;
    idle = st(0,0,0,0,0,0,4'd0,3'b000);

    //              sof p  en up dn bd id     bullet      cd dg sc      am     kc
    tbl[0]  = mk(st(0,0,1,0,0,0,4'd1,3'b110), 0,0,3'b010,2'b11,8'd0);
    tbl[1]  = mk(st(0,0,1,0,0,0,4'd1,3'b110), 0,0,3'b000,2'b11,8'd0);
    tbl[2]  = mk(st(1,0,0,0,0,0,4'd0,3'b000), 0,0,3'b000,2'b11,8'd0);
    tbl[3]  = mk(st(0,0,1,0,0,0,4'd1,3'b110), 0,0,3'b010,2'b11,8'd0);
    tbl[4]  = mk(st(0,0,1,0,0,1,4'd0,3'b001), 1,0,3'b001,2'b11,8'd0);
    tbl[5]  = mk(st(1,0,0,0,0,0,4'd0,3'b000), 0,0,3'b000,2'b11,8'd0);
    tbl[6]  = mk(st(0,0,1,0,0,0,4'd0,3'b100), 0,0,3'b100,2'b11,8'd0);
    tbl[7]  = mk(st(1,0,0,0,0,0,4'd0,3'b000), 0,0,3'b000,2'b11,8'd0);
    tbl[8]  = mk(st(0,0,0,1,0,0,4'd0,3'b001), 0,1,3'b000,2'b11,8'd0);
    tbl[9]  = mk(st(0,0,1,0,0,0,4'd0,3'b001), 0,0,3'b001,2'b11,8'd0);
    tbl[10] = mk(st(0,0,1,0,0,1,4'd0,3'b001), 0,0,3'b000,2'b10,8'd1);
    tbl[11] = mk(st(0,0,1,0,0,1,4'd5,3'b001), 0,0,3'b000,2'b10,8'd1);
    tbl[12] = mk(st(0,1,1,0,0,1,4'd1,3'b000), 0,0,3'b000,2'b10,8'd1);
    tbl[13] = mk(st(0,0,1,0,0,1,4'd1,3'b000), 1,0,3'b000,2'b10,8'd1);
    tbl[14] = mk(st(0,0,1,0,0,1,4'd1,3'b000), 0,0,3'b000,2'b10,8'd1);
    tbl[15] = mk(st(0,0,0,1,0,0,4'd1,3'b000), 0,0,3'b000,2'b10,8'd1);

    resetN = 1'b1;
    drive(idle);
    modelReset();
    @(posedge clk);
    #1;
    check("reset.aliveMap", 8'(aliveMap), 8'h03);
    check("reset.killCount", killCount, 8'd0);
    check("reset.waveNum", 8'(waveNum), 8'd0);
    check("reset.waveClear", 8'(waveClear), 8'd0);
    @(negedge clk);
    resetN = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyAndCheck(tbl[i].in);
      $display("[TB] vec %0d id=%0d bullet=%b -> cd=%b dg=%b shot=%b alive=%b kills=%0d",
               i, tbl[i].in.id, tbl[i].in.bullet, changeDir, dodgeBullet,
               shotCollision, aliveMap, killCount);
      check("tbl.changeDir", 8'(changeDir), 8'(tbl[i].cd));
      check("tbl.dodgeBullet", 8'(dodgeBullet), 8'(tbl[i].dg));
      check("tbl.shotCollision", 8'(shotCollision), 8'(tbl[i].sc));
      check("tbl.aliveMap", 8'(aliveMap), 8'(tbl[i].am));
      check("tbl.killCount", killCount, tbl[i].kc);
    end

    // Kill the last enemy, confirm the silent cleared wave, then restart.
    applyAndCheck(st(1,0,0,0,0,0,4'd0,3'b000));
    applyAndCheck(st(0,0,1,0,0,0,4'd1,3'b010));
    check("wave.lastShot", 8'(shotCollision), 8'h02);
    applyAndCheck(idle);
    check("wave.allDead", 8'(aliveMap), 8'h00);
    check("wave.kills", killCount, 8'd2);
    applyAndCheck(st(0,0,1,0,0,1,4'd1,3'b001));
    check("wave.noEvents", 8'({changeDir, dodgeBullet, shotCollision}), 8'h00);
    applyAndCheck(st(1,0,0,0,0,0,4'd0,3'b000));
    applyAndCheck(idle);
    $display("[TB] wave restart: waveClear=%b alive=%b waveNum=%0d", waveClear, aliveMap, waveNum);
    check("wave.clearPulse", 8'(waveClear), 8'd1);
    check("wave.revived", 8'(aliveMap), 8'h03);
    check("wave.num", 8'(waveNum), 8'd1);
    applyAndCheck(idle);
    check("wave.pulseEnd", 8'(waveClear), 8'd0);

    // Two hits on enemy 0, then an asynchronous reset in the middle of a cycle.
    applyAndCheck(st(1,0,0,0,0,0,4'd0,3'b000));
    applyAndCheck(st(0,0,1,0,0,0,4'd0,3'b001));
    applyAndCheck(st(1,0,0,0,0,0,4'd0,3'b000));
    applyAndCheck(st(0,0,1,0,0,0,4'd0,3'b001));
    @(negedge clk);
    drive(st(0,0,1,0,0,1,4'd1,3'b010));
    #2;
    resetN = 1'b1;
    #1;
    $display("[TB] async reset: alive=%b kills=%0d cd=%b shot=%b", aliveMap, killCount, changeDir, shotCollision);
    check("areset.aliveMap", 8'(aliveMap), 8'h03);
    check("areset.killCount", killCount, 8'd0);
    check("areset.waveNum", 8'(waveNum), 8'd0);
    check("areset.events", 8'({changeDir, dodgeBullet, shotCollision}), 8'h00);
    @(negedge clk);
    drive(idle);
    resetN = 1'b0;
    modelReset();

    // Random pixels; frame starts carry no draw requests.
    for (int c = 0; c < 3000; c++) begin
      rs = idle;
      rs.sof   = ($urandom_range(0, 15) == 0);
      rs.pause = ($urandom_range(0, 9) == 0);
      if (!rs.sof) begin
        rs.enemy  = 1'($urandom_range(0, 1));
        rs.up     = 1'($urandom_range(0, 1));
        rs.down   = 1'($urandom_range(0, 1));
        rs.border = 1'($urandom_range(0, 1));
        rs.id     = 4'($urandom_range(0, 3));
        rs.bullet = 3'($urandom_range(0, 7));
      end
      applyAndCheck(rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
